// File: rtl/axis_loopback_fifo.sv
// rtl/axis_loopback_fifo.sv - AXI4-Stream loopback FIFO with optional SPT/DPT swap and packet status
// Define AXIS_LOOPBACK_FIFO_STORE_FWD_EN to hold egress until a whole packet is buffered.
module axis_loopback_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 128,
  parameter int DEPTH      = 16,
  parameter int SWAP_PORTS = 1
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_DAT_TDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXIS_DAT_TSTRB,
  input  logic [USER_WIDTH-1:0]     S_AXIS_DAT_TUSER,
  input  logic                      S_AXIS_DAT_TLAST,
  input  logic                      S_AXIS_DAT_TVALID,
  output logic                      S_AXIS_DAT_TREADY,
  output logic [DATA_WIDTH-1:0]     M_AXIS_DAT_TDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_DAT_TSTRB,
  output logic [USER_WIDTH-1:0]     M_AXIS_DAT_TUSER,
  output logic                      M_AXIS_DAT_TLAST,
  output logic                      M_AXIS_DAT_TVALID,
  input  logic                      M_AXIS_DAT_TREADY,
  output logic [$clog2(DEPTH):0]    FIFO_LEVEL,
  output logic [31:0]               PKT_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + SW + USER_WIDTH + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // Entry layout: {TDATA, TSTRB, TUSER, TLAST}, TLAST in bit 0.
  logic [EW-1:0]         r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_s_tready;
  logic [31:0]           r_pkt_count;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_pop_last;
  logic                  w_m_tvalid;
  logic [LW-1:0]         w_level_next;
  logic [EW-1:0]         w_head;
  logic [USER_WIDTH-1:0] w_head_user;
  logic [USER_WIDTH-1:0] w_out_user;

  assign w_push      = S_AXIS_DAT_TVALID && r_s_tready;
  assign w_pop       = w_m_tvalid && M_AXIS_DAT_TREADY;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_pop_last  = w_pop && w_head[0];
  assign w_head_user = w_head[USER_WIDTH:1];

  always_comb begin
    w_out_user = w_head_user;
    if (SWAP_PORTS != 0) begin
      w_out_user[31:24] = w_head_user[23:16];
      w_out_user[23:16] = w_head_user[31:24];
    end
  end

  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + LW'(1);
    end else if (w_pop && !w_push) begin
      w_level_next = r_level - LW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {S_AXIS_DAT_TDATA, S_AXIS_DAT_TSTRB, S_AXIS_DAT_TUSER, S_AXIS_DAT_TLAST};
    end
  end

  // Ready looks at next-cycle level, so a same-cycle pop never opens a slot in a full FIFO.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_s_tready  <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_level    <= w_level_next;
      r_s_tready <= (w_level_next != FULL_LVL);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_pop_last) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end
  end

`ifdef AXIS_LOOPBACK_FIFO_STORE_FWD_EN
  logic [LW-1:0] r_cmplt;
  logic          r_ovf;
  logic          w_push_last;

  assign w_push_last = w_push && S_AXIS_DAT_TLAST;

  // ovf lets a packet longer than the FIFO stream through instead of deadlocking.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_cmplt <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_last && !w_pop_last) begin
        r_cmplt <= r_cmplt + LW'(1);
      end else if (w_pop_last && !w_push_last) begin
        r_cmplt <= r_cmplt - LW'(1);
      end
      if (w_pop_last) begin
        r_ovf <= 1'b0;
      end else if (r_level == FULL_LVL && r_cmplt == '0) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign w_m_tvalid = (r_level != '0) && ((r_cmplt != '0) || r_ovf);
`else
  assign w_m_tvalid = (r_level != '0);
`endif

  assign S_AXIS_DAT_TREADY = r_s_tready;
  assign M_AXIS_DAT_TVALID = w_m_tvalid;
  assign M_AXIS_DAT_TDATA  = w_head[EW-1:EW-DATA_WIDTH];
  assign M_AXIS_DAT_TSTRB  = w_head[USER_WIDTH+SW:USER_WIDTH+1];
  assign M_AXIS_DAT_TUSER  = w_out_user;
  assign M_AXIS_DAT_TLAST  = w_head[0];
  assign FIFO_LEVEL        = r_level;
  assign PKT_COUNT         = r_pkt_count;

endmodule

// File: tb/tb_axis_loopback_fifo.sv
// tb/tb_axis_loopback_fifo.sv - scoreboard bench for axis_loopback_fifo (cut-through or AXIS_LOOPBACK_FIFO_STORE_FWD_EN)
`timescale 1ns/1ps
module tb_axis_loopback_fifo;

  localparam int DW    = 32;
  localparam int UW    = 128;
  localparam int DEPTH = 16;
  localparam int SW    = DW / 8;
  localparam int EW    = DW + SW + UW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [SW-1:0] s_tstrb = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [4:0]    fifo_level;
  logic [31:0]   pkt_count;

  int            vectors = 0;
  int            miscompares = 0;
  int            exp_pkts = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];

  axis_loopback_fifo #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH), .SWAP_PORTS(1)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXIS_DAT_TDATA(s_tdata), .S_AXIS_DAT_TSTRB(s_tstrb), .S_AXIS_DAT_TUSER(s_tuser),
    .S_AXIS_DAT_TLAST(s_tlast), .S_AXIS_DAT_TVALID(s_tvalid), .S_AXIS_DAT_TREADY(s_tready),
    .M_AXIS_DAT_TDATA(m_tdata), .M_AXIS_DAT_TSTRB(m_tstrb), .M_AXIS_DAT_TUSER(m_tuser),
    .M_AXIS_DAT_TLAST(m_tlast), .M_AXIS_DAT_TVALID(m_tvalid), .M_AXIS_DAT_TREADY(m_tready),
    .FIFO_LEVEL(fifo_level), .PKT_COUNT(pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [UW-1:0] swap_user(input logic [UW-1:0] u);
    logic [UW-1:0] r;
    r = u;
    r[31:24] = u[23:16];
    r[23:16] = u[31:24];
    return r;
  endfunction

  // Record handshakes at the falling edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (s_tvalid && s_tready) exp_q.push_back({s_tdata, s_tstrb, swap_user(s_tuser), s_tlast});
    if (m_tvalid && m_tready) got_q.push_back({m_tdata, m_tstrb, m_tuser, m_tlast});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    repeat (3) tick();
    vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL reset_s_tready: got %b expected 0", s_tready); end
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    vectors++; if (pkt_count !== 32'd0) begin miscompares++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
    rst_n = 1'b1;
    #1;
    vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL tready_before_edge: got %b expected 0", s_tready); end
    tick();
    vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL tready_after_release: got %b expected 1", s_tready); end
  endtask

  task automatic test_single_packet();
    logic [EW-1:0] g;
    logic [EW-1:0] e;
    exp_q.delete(); got_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(i + 1); s_tstrb = '1; s_tlast = (i == 3);
      s_tuser = {$urandom(), $urandom(), $urandom(), 16'h0102, 16'h5a5a};
      tick();
`ifndef AXIS_LOOPBACK_FIFO_STORE_FWD_EN
      if (i == 0) begin
        vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL single_latency: m_tvalid got %b expected 1", m_tvalid); end
      end
`endif
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int c = 0; c < 20 && got_q.size() < 4; c++) tick();
    exp_pkts++;
    vectors++; if (got_q.size() != 4) begin miscompares++; $display("FAIL single_count: got %0d beats expected 4", got_q.size()); end
    for (int i = 0; i < 4 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL single_beat%0d: got %h expected %h", i, g, e); end
      vectors++;
      if ({g[EW-1 -: DW], g[32:17], g[0]} !== {DW'(i + 1), 16'h0201, (i == 3)}) begin
        miscompares++; $display("FAIL single_fields%0d: data %0h spt_dpt %h last %b expected %0d 0201 %b", i, g[EW-1 -: DW], g[32:17], g[0], i + 1, (i == 3));
      end
    end
    vectors++; if (pkt_count !== 32'(exp_pkts)) begin miscompares++; $display("FAIL single_pkt_count: got %0d expected %0d", pkt_count, exp_pkts); end
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL single_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_full();
    logic [EW-1:0] g;
    logic [EW-1:0] e;
    int sent;
    bit checked;
    exp_q.delete(); got_q.delete();
    sent = 0; checked = 1'b0;
    m_tready = 1'b0;
    for (int c = 0; c < 24; c++) begin
      s_tvalid = 1'b1; s_tdata = DW'(32'h100 + sent); s_tstrb = SW'($urandom());
      s_tuser = {$urandom(), $urandom(), $urandom(), $urandom()}; s_tlast = (sent == 19);
      tick();
      sent = exp_q.size();
      if (sent == 16 && !checked) begin
        checked = 1'b1;
        vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL full_tready_drop: got %b expected 0", s_tready); end
      end
    end
    vectors++; if (sent != 16) begin miscompares++; $display("FAIL full_accepted: got %0d expected 16", sent); end
    vectors++; if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL full_level: got %0d expected 16", fifo_level); end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    tick();
    vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL full_tready_return: got %b expected 1", s_tready); end
    vectors++; if (fifo_level !== 5'd15) begin miscompares++; $display("FAIL full_level_after_pop: got %0d expected 15", fifo_level); end
    for (int c = 0; c < 80 && got_q.size() < 20; c++) begin
      s_tvalid = (sent < 20); s_tdata = DW'(32'h100 + sent); s_tstrb = SW'($urandom());
      s_tuser = {$urandom(), $urandom(), $urandom(), $urandom()}; s_tlast = (sent == 19);
      tick();
      sent = exp_q.size();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    exp_pkts++;
    vectors++; if (got_q.size() != 20) begin miscompares++; $display("FAIL full_drain_count: got %0d expected 20", got_q.size()); end
    for (int i = 0; i < 20 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e || g[EW-1 -: DW] !== DW'(32'h100 + i)) begin
        miscompares++; $display("FAIL full_beat%0d: got %h expected %h", i, g, e);
      end
    end
    vectors++; if (pkt_count !== 32'(exp_pkts)) begin miscompares++; $display("FAIL full_pkt_count: got %0d expected %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] g;
    logic [EW-1:0] e;
    exp_q.delete(); got_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'($urandom()); s_tstrb = SW'($urandom());
      s_tuser = {$urandom(), $urandom(), $urandom(), $urandom()}; s_tlast = ((i % 10) == 9);
      tick();
`ifndef AXIS_LOOPBACK_FIFO_STORE_FWD_EN
      vectors++; if (fifo_level !== 5'd1) begin miscompares++; $display("FAIL b2b_level%0d: got %0d expected 1", i, fifo_level); end
`endif
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int c = 0; c < 40 && got_q.size() < 100; c++) tick();
    exp_pkts += 10;
    vectors++; if (exp_q.size() != 100) begin miscompares++; $display("FAIL b2b_accepted: got %0d expected 100", exp_q.size()); end
    vectors++; if (got_q.size() != 100) begin miscompares++; $display("FAIL b2b_count: got %0d expected 100", got_q.size()); end
    for (int i = 0; i < 100 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL b2b_beat%0d: got %h expected %h", i, g, e); end
    end
    vectors++; if (pkt_count !== 32'(exp_pkts)) begin miscompares++; $display("FAIL b2b_pkt_count: got %0d expected %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_reset_mid_packet();
    logic [EW-1:0] g;
    logic [EW-1:0] e;
    exp_q.delete(); got_q.delete();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(32'hdead0000 + i); s_tstrb = '1;
      s_tuser = {$urandom(), $urandom(), $urandom(), $urandom()}; s_tlast = 1'b0;
      tick();
    end
    s_tvalid = 1'b0;
    vectors++; if (fifo_level !== 5'd5) begin miscompares++; $display("FAIL rst_mid_level_before: got %0d expected 5", fifo_level); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL rst_mid_level: got %0d expected 0", fifo_level); end
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_tvalid: got %b expected 0", m_tvalid); end
    vectors++; if (pkt_count !== 32'd0) begin miscompares++; $display("FAIL rst_mid_pkt_count: got %0d expected 0", pkt_count); end
    exp_q.delete(); got_q.delete(); exp_pkts = 0;
    tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_tready: got %b expected 1", s_tready); end
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(32'hbeef0000 + i); s_tstrb = SW'($urandom());
      s_tuser = {$urandom(), $urandom(), $urandom(), $urandom()}; s_tlast = (i == 2);
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int c = 0; c < 20 && got_q.size() < 3; c++) tick();
    exp_pkts++;
    vectors++; if (got_q.size() != 3) begin miscompares++; $display("FAIL rst_mid_count: got %0d expected 3", got_q.size()); end
    for (int i = 0; i < 3 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL rst_mid_beat%0d: got %h expected %h", i, g, e); end
    end
    vectors++; if (pkt_count !== 32'd1) begin miscompares++; $display("FAIL rst_mid_pkt_after: got %0d expected 1", pkt_count); end
  endtask

`ifdef AXIS_LOOPBACK_FIFO_STORE_FWD_EN
  task automatic test_store_fwd();
    logic [EW-1:0] g;
    logic [EW-1:0] e;
    exp_q.delete(); got_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_tvalid = (i < 2) || (i == 7); s_tdata = DW'(32'h5f00 + i); s_tstrb = '1;
      s_tuser = {$urandom(), $urandom(), $urandom(), $urandom()}; s_tlast = (i == 7);
      tick();
      if (i < 7) begin
        vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL sf_gated%0d: m_tvalid got %b expected 0", i, m_tvalid); end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL sf_release: m_tvalid got %b expected 1", m_tvalid); end
    for (int c = 0; c < 20 && got_q.size() < 3; c++) tick();
    exp_pkts++;
    vectors++; if (got_q.size() != 3) begin miscompares++; $display("FAIL sf_count: got %0d expected 3", got_q.size()); end
    for (int i = 0; i < 3 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL sf_beat%0d: got %h expected %h", i, g, e); end
    end
    vectors++; if (pkt_count !== 32'(exp_pkts)) begin miscompares++; $display("FAIL sf_pkt_count: got %0d expected %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_ovf();
    logic [EW-1:0] g;
    logic [EW-1:0] e;
    int sent;
    int lvl_at_valid;
    exp_q.delete(); got_q.delete();
    sent = 0; lvl_at_valid = -1;
    m_tready = 1'b1;
    for (int c = 0; c < 120 && got_q.size() < 20; c++) begin
      s_tvalid = (sent < 20); s_tdata = DW'(32'h7700 + sent); s_tstrb = SW'($urandom());
      s_tuser = {$urandom(), $urandom(), $urandom(), $urandom()}; s_tlast = (sent == 19);
      tick();
      sent = exp_q.size();
      if (lvl_at_valid < 0 && m_tvalid) lvl_at_valid = int'(fifo_level);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    exp_pkts++;
    vectors++; if (lvl_at_valid != 16) begin miscompares++; $display("FAIL ovf_level_at_release: got %0d expected 16", lvl_at_valid); end
    vectors++; if (got_q.size() != 20) begin miscompares++; $display("FAIL ovf_count: got %0d expected 20", got_q.size()); end
    for (int i = 0; i < 20 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL ovf_beat%0d: got %h expected %h", i, g, e); end
    end
    vectors++; if (pkt_count !== 32'(exp_pkts)) begin miscompares++; $display("FAIL ovf_pkt_count: got %0d expected %0d", pkt_count, exp_pkts); end
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL ovf_level_end: got %0d expected 0", fifo_level); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_packet();
    test_full();
    test_back_to_back();
    test_reset_mid_packet();
`ifdef AXIS_LOOPBACK_FIFO_STORE_FWD_EN
    test_store_fwd();
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
